// File: rtl/stump_mem_pkg.sv
// Shared types and constants for the Stump memory responder.
package stump_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } mem_state_t;

  localparam logic [1:0]  IO_LED    = 2'd0;
  localparam logic [1:0]  IO_TIMER  = 2'd1;
  localparam logic [1:0]  IO_STATUS = 2'd2;
  localparam logic [15:0] READ_ZERO = 16'h0000;

  // True when the word address falls inside the 2^addr_w word RAM.
  function automatic logic in_ram(input logic [15:0] addr, input int addr_w);
    return (({16'h0000, addr}) >> addr_w) == 32'h0;
  endfunction

endpackage

// File: rtl/stump_mem_ram.sv
// Single-port synchronous word RAM with write enable and registered read.
module stump_mem_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stump_mem_responder.sv
// Stump bus memory responder: word RAM plus 4-word I/O window with wait states.
// Optional free-running timer at IO_BASE+1 is built when STUMP_MEM_TIMER_EN is defined.
module stump_mem_responder
  import stump_mem_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] IO_BASE     = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic [15:0] rdata,
  output logic        mem_ready,
  output logic        bus_err,
  output logic [15:0] leds
);

  mem_state_t  state_reg;
  logic [2:0]  cnt_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        wr_reg;
  logic        mem_ready_reg;
  logic        bus_err_reg;
  logic        ram_rd_reg;
  logic [15:0] io_rdata_reg;
  logic [15:0] leds_reg;
  logic        status_reg;

  logic        ram_sel;
  logic        io_sel;
  logic        unmapped;
  logic [15:0] io_off;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_q;
  logic [15:0] io_rd_value;

  assign ram_sel  = in_ram(addr_reg, ADDR_W);
  assign io_off   = addr_reg - IO_BASE;
  assign io_sel   = !ram_sel && (io_off < 16'd4);
  assign unmapped = !ram_sel && !io_sel;
  assign ram_we   = (state_reg == ST_ACCESS) && wr_reg && ram_sel;
  assign ram_re   = (state_reg == ST_ACCESS) && !wr_reg && ram_sel;

`ifdef STUMP_MEM_TIMER_EN
  logic [15:0] timer_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_reg <= 16'h0000;
    end else begin
      timer_reg <= timer_reg + 16'd1;
    end
  end
`endif

  always_comb begin
    io_rd_value = READ_ZERO;
    if (io_sel) begin
      case (io_off[1:0])
        IO_LED:    io_rd_value = leds_reg;
`ifdef STUMP_MEM_TIMER_EN
        IO_TIMER:  io_rd_value = timer_reg;
`endif
        IO_STATUS: io_rd_value = {15'h0000, status_reg};
        default:   io_rd_value = READ_ZERO;
      endcase
    end
  end

  stump_mem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_reg[ADDR_W-1:0]),
    .wdata (wdata_reg),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 3'd0;
      addr_reg      <= 16'h0000;
      wdata_reg     <= 16'h0000;
      wr_reg        <= 1'b0;
      mem_ready_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
      ram_rd_reg    <= 1'b0;
      io_rdata_reg  <= READ_ZERO;
      leds_reg      <= 16'h0000;
      status_reg    <= 1'b0;
    end else begin
      mem_ready_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mem_rd && mem_wr) begin
            // Conflicting strobes: complete immediately as an error, no access.
            state_reg     <= ST_DONE;
            mem_ready_reg <= 1'b1;
            bus_err_reg   <= 1'b1;
            status_reg    <= 1'b1;
            ram_rd_reg    <= 1'b0;
            io_rdata_reg  <= READ_ZERO;
          end else if (mem_rd ^ mem_wr) begin
            addr_reg  <= address;
            wdata_reg <= wdata;
            wr_reg    <= mem_wr;
            cnt_reg   <= 3'(WAIT_STATES);
            state_reg <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            state_reg <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state_reg     <= ST_DONE;
          mem_ready_reg <= 1'b1;
          bus_err_reg   <= unmapped;
          ram_rd_reg    <= ram_re;
          io_rdata_reg  <= wr_reg ? READ_ZERO : io_rd_value;
          if (wr_reg && io_sel && (io_off[1:0] == IO_LED)) begin
            leds_reg <= wdata_reg;
          end
          // A new error wins over a same-access clear of the sticky bit.
          if (unmapped) begin
            status_reg <= 1'b1;
          end else if (wr_reg && io_sel && (io_off[1:0] == IO_STATUS) && wdata_reg[0]) begin
            status_reg <= 1'b0;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM data is captured by the RAM's own output register on the ACCESS edge.
  assign rdata     = mem_ready_reg ? (ram_rd_reg ? ram_q : io_rdata_reg) : READ_ZERO;
  assign mem_ready = mem_ready_reg;
  assign bus_err   = bus_err_reg;
  assign leds      = leds_reg;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Scoreboard bench: unit 0 runs with one wait state, unit 1 with none.
module tb_stump_mem_responder;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        chk_data;
    int          lat;
    int          issue;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n [2];
  logic [15:0] addr  [2];
  logic [15:0] wd    [2];
  logic        mrd   [2];
  logic        mwr   [2];
  logic [15:0] rdata [2];
  logic        rdy   [2];
  logic        berr  [2];
  logic [15:0] leds  [2];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] last_rdata;
  int          last_issue;

  stump_mem_responder #(.ADDR_W(12), .WAIT_STATES(1), .IO_BASE(16'hFF00)) u0 (
    .clk(clk), .rst(rst_n[0]), .address(addr[0]), .wdata(wd[0]),
    .mem_rd(mrd[0]), .mem_wr(mwr[0]), .rdata(rdata[0]),
    .mem_ready(rdy[0]), .bus_err(berr[0]), .leds(leds[0])
  );

  stump_mem_responder #(.ADDR_W(12), .WAIT_STATES(0), .IO_BASE(16'hFF00)) u1 (
    .clk(clk), .rst(rst_n[1]), .address(addr[1]), .wdata(wd[1]),
    .mem_rd(mrd[1]), .mem_wr(mwr[1]), .rdata(rdata[1]),
    .mem_ready(rdy[1]), .bus_err(berr[1]), .leds(leds[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    logic have;
    have = 1'b0;
    if (i == 0 && q0.size() > 0) begin
      e = q0.pop_front();
      have = 1'b1;
    end else if (i == 1 && q1.size() > 0) begin
      e = q1.pop_front();
      have = 1'b1;
    end
    if (!have) begin
      tests++;
      fails++;
      $display("FAIL u%0d_unexpected_ready: got mem_ready=1 at cycle %0d expected no response", i, cyc);
    end else begin
      check($sformatf("u%0d_%s_bus_err", i, e.name), {31'h0, berr[i]}, {31'h0, e.err});
      if (e.chk_data)
        check($sformatf("u%0d_%s_rdata", i, e.name), {16'h0, rdata[i]}, {16'h0, e.data});
      check($sformatf("u%0d_%s_latency", i, e.name), cyc - e.issue, e.lat);
    end
  endtask

  always @(negedge clk) begin
    if (rdy[0]) mon(0);
    if (rdy[1]) mon(1);
  end

  // Called just after a rising edge; returns just after the edge that closes DONE.
  task automatic access(input int i, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] ed, input logic ee,
                        input logic cd, input int lat, input string name);
    exp_t e;
    int n;
    e.data = ed; e.err = ee; e.chk_data = cd; e.lat = lat; e.issue = cyc; e.name = name;
    last_issue = cyc;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    mrd[i] = rd; mwr[i] = wr; addr[i] = a; wd[i] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[i] && n < 20);
    if (!rdy[i]) begin
      tests++;
      fails++;
      $display("FAIL u%0d_%s_timeout: got no mem_ready in %0d cycles expected one", i, name, n);
    end
    last_rdata = rdata[i];
    @(posedge clk);
    #1;
    mrd[i] = 1'b0; mwr[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t1;
    int          c1;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; addr[i] = 16'h0; wd[i] = 16'h0; mrd[i] = 1'b0; mwr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    check("reset_mem_ready", {31'h0, rdy[0]}, 32'h0);
    check("reset_bus_err", {31'h0, berr[0]}, 32'h0);
    check("reset_rdata", {16'h0, rdata[0]}, 32'h0);
    check("reset_leds", {16'h0, leds[0]}, 32'h0);
    check("reset_leds_u1", {16'h0, leds[1]}, 32'h0);
    @(posedge clk);
    #1;

    // One wait state: 3-cycle latency.
    access(0, 0, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, 0, 3, "wr_0010");
    access(0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1, 3, "rd_0010");
    check("rdata_zero_after_done", {16'h0, rdata[0]}, 32'h0);

    access(0, 0, 1, 16'hFF00, 16'h00A5, 16'h0000, 0, 0, 3, "wr_led");
    check("leds_after_write", {16'h0, leds[0]}, 32'h0000_00A5);
    access(0, 1, 0, 16'hFF00, 16'h0000, 16'h00A5, 0, 1, 3, "rd_led");

    access(0, 1, 0, 16'h8000, 16'h0000, 16'h0000, 1, 1, 3, "rd_unmapped");
    access(0, 1, 0, 16'hFF02, 16'h0000, 16'h0001, 0, 1, 3, "rd_status_set");
    access(0, 0, 1, 16'hFF02, 16'h0001, 16'h0000, 0, 0, 3, "wr_status_clr");
    access(0, 1, 0, 16'hFF02, 16'h0000, 16'h0000, 0, 1, 3, "rd_status_clr");

    access(0, 0, 1, 16'h0020, 16'h1234, 16'h0000, 0, 0, 3, "wr_0020");
    access(0, 1, 1, 16'h0020, 16'hDEAD, 16'h0000, 1, 1, 1, "rdwr_0020");
    access(0, 1, 0, 16'h0020, 16'h0000, 16'h1234, 0, 1, 3, "rd_0020");
    access(0, 1, 0, 16'hFF02, 16'h0000, 16'h0001, 0, 1, 3, "rd_status_strobe");

    access(0, 0, 1, 16'hFF01, 16'h5555, 16'h0000, 0, 0, 3, "wr_timer");
    access(0, 0, 1, 16'hFF03, 16'h7777, 16'h0000, 0, 0, 3, "wr_io3");
    access(0, 1, 0, 16'hFF03, 16'h0000, 16'h0000, 0, 1, 3, "rd_io3");
`ifdef STUMP_MEM_TIMER_EN
    access(0, 1, 0, 16'hFF01, 16'h0000, 16'h0000, 0, 0, 3, "rd_timer_a");
    t1 = last_rdata;
    c1 = last_issue;
    access(0, 1, 0, 16'hFF01, 16'h0000, 16'h0000, 0, 0, 3, "rd_timer_b");
    check("timer_delta", {16'h0, 16'(last_rdata - t1)}, {16'h0, 16'(last_issue - c1)});
`else
    t1 = 16'h0;
    c1 = 0;
    access(0, 1, 0, 16'hFF01, 16'h0000, 16'h0000, 0, 1, 3, "rd_timer_off");
`endif

    // Reset during WAIT of a write abandons it.
    access(0, 0, 1, 16'h0030, 16'h1111, 16'h0000, 0, 0, 3, "wr_0030");
    mwr[0] = 1'b1; addr[0] = 16'h0030; wd[0] = 16'h2222;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    mwr[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_abort_ready", {31'h0, rdy[0]}, 32'h0);
    end
    check("reset_abort_leds", {16'h0, leds[0]}, 32'h0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk);
    #1;
    access(0, 1, 0, 16'h0030, 16'h0000, 16'h1111, 0, 1, 3, "rd_0030_after_rst");

    // Zero wait states: 2-cycle latency, back-to-back.
    access(1, 0, 1, 16'h0000, 16'hA001, 16'h0000, 0, 0, 2, "wr_0000");
    access(1, 0, 1, 16'h0001, 16'hA002, 16'h0000, 0, 0, 2, "wr_0001");
    access(1, 1, 0, 16'h0000, 16'h0000, 16'hA001, 0, 1, 2, "rd_0000");
    access(1, 1, 0, 16'h0001, 16'h0000, 16'hA002, 0, 1, 2, "rd_0001");

    repeat (4) @(posedge clk);
    check("scoreboard_drained", q0.size() + q1.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
